// File: rtl/calc_mem_pkg.sv
// -----------------------------------------------------------------------------
// calc_mem_pkg
// Shared types and default constants for the CalcuTEC unified memory.
//   - mem_state_e : controller state (MEM_CLEAR while the array is being
//                   zeroed, MEM_RUN afterwards)
//   - ld_entry_t  : one loader FIFO entry {addr, data} at the default geometry
//   - CALC_MEM_*  : default data width, depth, address width, FIFO depth
// Optional feature macro used by the files that import this package:
//   MEM_BYTE_WE_EN - adds per-byte CPU write enables.
// -----------------------------------------------------------------------------
package calc_mem_pkg;

    localparam int CALC_MEM_DW       = 32;
    localparam int CALC_MEM_DEPTH    = 32;
    localparam int CALC_MEM_AW       = $clog2(CALC_MEM_DEPTH);
    localparam int CALC_MEM_LD_DEPTH = 2;

    typedef enum logic {
        MEM_CLEAR = 1'b0,
        MEM_RUN   = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [CALC_MEM_AW-1:0] addr;
        logic [CALC_MEM_DW-1:0] data;
    } ld_entry_t;

endpackage

// File: rtl/calc_mem_if.sv
// -----------------------------------------------------------------------------
// calc_mem_if
// Bundles the three access ports of calc_memory:
//   CPU    : cpu_addr, cpu_wdata, cpu_we, (cpu_be), cpu_rdata
//   Loader : ld_valid, ld_ready, ld_addr, ld_data, ld_idle
//   Result : res_rd, res_addr, res_data, res_valid
//   Status : busy
// Loader handshake: a word transfers on a rising edge where ld_valid and
// ld_ready are both 1; ld_ready never depends on ld_valid in the same cycle.
// Modports: master = the side issuing requests, slave = the memory.
// Macro MEM_BYTE_WE_EN adds cpu_be (one enable bit per data byte).
// -----------------------------------------------------------------------------
interface calc_mem_if
    import calc_mem_pkg::*;
#(
    parameter int DW = CALC_MEM_DW,
    parameter int AW = CALC_MEM_AW
);
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            cpu_we;
`ifdef MEM_BYTE_WE_EN
    logic [DW/8-1:0] cpu_be;
`endif
    logic [DW-1:0]   cpu_rdata;

    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            ld_idle;

    logic            res_rd;
    logic [AW-1:0]   res_addr;
    logic [DW-1:0]   res_data;
    logic            res_valid;

    logic            busy;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we,
`ifdef MEM_BYTE_WE_EN
        output cpu_be,
`endif
        output ld_valid, ld_addr, ld_data, res_rd, res_addr,
        input  cpu_rdata, ld_ready, ld_idle, res_data, res_valid, busy
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we,
`ifdef MEM_BYTE_WE_EN
        input  cpu_be,
`endif
        input  ld_valid, ld_addr, ld_data, res_rd, res_addr,
        output cpu_rdata, ld_ready, ld_idle, res_data, res_valid, busy
    );

endinterface

// File: rtl/calc_mem_load_fifo.sv
// -----------------------------------------------------------------------------
// calc_mem_load_fifo
// Small synchronous FIFO that buffers loader words ahead of the memory write
// port. Synchronous active-high reset empties it.
// Ports:
//   clk, rst   : clock, synchronous reset (flushes all entries)
//   push_i     : write wdata_i at the tail (ignored when full and not popping)
//   wdata_i    : entry to enqueue
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : current head entry, read from registered storage/pointer
//   full_o     : all DEPTH entries occupied (from the registered count)
//   empty_o    : no entries (from the registered count)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module calc_mem_load_fifo
    import calc_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = CALC_MEM_LD_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = buf_q[rd_ptr_q];

    // A full FIFO can still take a word if the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/calc_memory.sv
// -----------------------------------------------------------------------------
// calc_memory
// Unified data/instruction memory for the CalcuTEC datapath.
// Ports:
//   clk      : sole clock, all state updates on its rising edge
//   rst      : synchronous active-high reset; restarts the clear engine,
//              flushes the loader FIFO and drops any pending result
//   bus      : calc_mem_if.slave - CPU port (combinational read, write),
//              loader port (valid/ready into a FIFO), result port
//              (registered read, one-cycle latency), busy status
//   state_o  : current controller state, for observation
// After reset the clear engine writes 0 to every word (one per cycle); while
// it runs busy=1, CPU writes and result requests are ignored and ld_ready=0.
// In RUN the single write port goes to the CPU when cpu_we=1, otherwise to
// the loader FIFO head.
// Macro MEM_BYTE_WE_EN: enables cpu_be per-byte CPU write masking.
// -----------------------------------------------------------------------------
module calc_memory
    import calc_mem_pkg::*;
#(
    parameter int DW            = CALC_MEM_DW,
    parameter int DEPTH         = CALC_MEM_DEPTH,
    parameter int LD_FIFO_DEPTH = CALC_MEM_LD_DEPTH,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    calc_mem_if.slave  bus,
    output mem_state_e state_o
);
    localparam int BW = DW / 8;
    localparam int EW = AW + DW;

    mem_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] res_data_q;
    logic          res_valid_q;

    logic          run;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0] fifo_wdata, fifo_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_wmask;
    logic [BW-1:0] cpu_mask;

    assign run = (state_q == MEM_RUN);

`ifdef MEM_BYTE_WE_EN
    assign cpu_mask = bus.cpu_be;
`else
    assign cpu_mask = '1;
`endif

    // ---------------- clear engine / controller FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == MEM_CLEAR) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_d = MEM_RUN;
                ptr_d   = '0;
            end
        end
    end

    // ---------------- loader FIFO ----------------
    assign fifo_wdata = {bus.ld_addr, bus.ld_data};
    assign fifo_push  = bus.ld_valid && bus.ld_ready;
    // The head only drains on cycles the CPU leaves the write port free.
    assign fifo_pop   = run && !rst && !bus.cpu_we && !fifo_empty;

    calc_mem_load_fifo #(
        .WIDTH (EW),
        .DEPTH (LD_FIFO_DEPTH)
    ) u_load_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- write port arbiter ----------------
    // Nothing is written on a reset cycle; the clear that follows starts
    // from address 0 on the first cycle with rst low.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        mem_wmask = '1;
        if (!rst) begin
            if (!run) begin
                mem_we = 1'b1;
            end else if (bus.cpu_we) begin
                mem_we    = 1'b1;
                mem_waddr = bus.cpu_addr;
                mem_wdata = bus.cpu_wdata;
                mem_wmask = cpu_mask;
            end else if (!fifo_empty) begin
                mem_we    = 1'b1;
                mem_waddr = fifo_rdata[EW-1:DW];
                mem_wdata = fifo_rdata[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_wmask[b]) begin
                    mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- result port ----------------
    // mem_q is sampled before this edge's write lands, so a same-cycle
    // write to res_addr is not reflected until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= run && bus.res_rd;
            if (run && bus.res_rd) begin
                res_data_q <= mem_q[bus.res_addr];
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.cpu_rdata = run ? mem_q[bus.cpu_addr] : '0;
    assign bus.ld_ready  = run && !fifo_full;
    // No loader word is outstanding once the FIFO is empty: the head's write
    // and its pop happen on the same edge.
    assign bus.ld_idle   = fifo_empty;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = !run;
    assign state_o       = state_q;

endmodule

// File: tb/tb_calc_memory.sv
// -----------------------------------------------------------------------------
// tb_calc_memory
// Self-checking bench for calc_memory (DEPTH=32, DW=32, loader FIFO depth 2).
// A behavioural model (array + entry queue) is advanced once per clock from
// the same inputs the DUT sees; every cycle the DUT outputs are compared to it.
// Directed sequences and a vector table add constant-valued checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_calc_memory;
    import calc_mem_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LDD   = 2;

    logic       clk;
    logic       rst;
    mem_state_e state_o;

    calc_mem_if #(.DW(DW), .AW(AW)) bus ();

    calc_memory #(
        .DW            (DW),
        .DEPTH         (DEPTH),
        .LD_FIFO_DEPTH (LDD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    ld_entry_t   m_q [$];
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    bit          m_res_valid = 1'b0;
    logic [31:0] m_res_data = '0;
    bit          m_known = 1'b0;

    task automatic model_step();
        bit        acc;
        ld_entry_t e;
        if (rst) begin
            m_known     = 1'b1;
            m_run       = 1'b0;
            m_cnt       = 0;
            m_q.delete();
            m_res_valid = 1'b0;
            m_res_data  = '0;
        end else if (!m_run) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1'b1;
            m_res_valid = 1'b0;
        end else begin
            acc = bus.ld_valid && (m_q.size() < LDD);
            m_res_valid = bus.res_rd;
            if (bus.res_rd) m_res_data = m_mem[bus.res_addr];
            if (bus.cpu_we) begin
`ifdef MEM_BYTE_WE_EN
                for (int b = 0; b < DW/8; b++)
                    if (bus.cpu_be[b]) m_mem[bus.cpu_addr][b*8 +: 8] = bus.cpu_wdata[b*8 +: 8];
`else
                m_mem[bus.cpu_addr] = bus.cpu_wdata;
`endif
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_mem[e.addr] = e.data;
            end
            if (acc) begin
                e.addr = bus.ld_addr;
                e.data = bus.ld_data;
                m_q.push_back(e);
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs are checked at posedge+3, then
    // the model advances and the task returns at the next posedge+1.
    task automatic cycle();
        #2;
        if (m_known) begin
            chk("busy",      32'(bus.busy),      32'(!m_run));
            chk("ld_ready",  32'(bus.ld_ready),  32'(m_run && (m_q.size() < LDD)));
            chk("ld_idle",   32'(bus.ld_idle),   32'(m_q.size() == 0));
            chk("cpu_rdata", bus.cpu_rdata,      m_run ? m_mem[bus.cpu_addr] : 32'h0);
            chk("res_valid", 32'(bus.res_valid), 32'(m_res_valid));
            chk("res_data",  bus.res_data,       m_res_data);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_we    = 1'b0;
`ifdef MEM_BYTE_WE_EN
        bus.cpu_be    = '1;
`endif
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.res_rd    = 1'b0;
        bus.res_addr  = '0;
    endtask

    task automatic run_clear(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run_clear(n);
        chk("clear_len", 32'(n), 32'(DEPTH));
    endtask

    task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        int n;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            #1 acc = bus.ld_ready;
            cycle();
            n++;
        end
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic expect_word(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        #1 chk(name, bus.cpu_rdata, exp);
        cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        rst = 1'b1;
        set_idle();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        vecs[0] = '{1'b1, 5'd3,  32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{1'b1, 5'd4,  32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 5'd3,  32'h0000_0000, 32'h1234_5678};
        vecs[3] = '{1'b1, 5'd3,  32'h0000_0001, 32'h0000_0001};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 5'd0,  32'h8000_0000, 32'h8000_0000};
        vecs[6] = '{1'b0, 5'd4,  32'h0000_0000, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 5'd31, 32'h0000_0000, 32'hFFFF_FFFF};

        @(posedge clk);
        #1;

        // Clear sequence: first clear, fill with non-zero data, clear again.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = AW'(i);
            bus.cpu_wdata = 32'hF000_0000 | 32'(i + 1);
            cycle();
        end
        bus.cpu_we = 1'b0;
        expect_word("preload", 5'd17, 32'hF000_0012);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("busy_after_rst", 32'(bus.busy), 32'd1);
        chk("rdata_while_busy", bus.cpu_rdata, 32'h0);
        run_clear(n);
        chk("clear_len", 32'(n), 32'(DEPTH));
        chk("ready_after_clear", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) expect_word("clear_zero", AW'(i), 32'h0);

        // Loader burst, ld_valid held across words.
        for (int i = 0; i < 4; i++) push_word(AW'(i), 32'hA0 + 32'(i));
        bus.ld_valid = 1'b0;
        n = 0;
        while (!bus.ld_idle && n < 20) begin
            cycle();
            n++;
        end
        chk("burst_idle", 32'(bus.ld_idle), 32'd1);
        for (int i = 0; i < 4; i++) expect_word("burst_word", AW'(i), 32'hA0 + 32'(i));
        bus.res_rd   = 1'b1;
        bus.res_addr = 5'd2;
        cycle();
        bus.res_rd = 1'b0;
        #1;
        chk("burst_res_valid", 32'(bus.res_valid), 32'd1);
        chk("burst_res_data",  bus.res_data, 32'hA2);
        cycle();
        #1;
        chk("res_valid_pulse", 32'(bus.res_valid), 32'd0);
        chk("res_data_hold",   bus.res_data, 32'hA2);
        cycle();

        // Arbitration: CPU holds the write port for three cycles.
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 5'd5;
        bus.cpu_wdata = 32'h11;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 5'd5;
        bus.ld_data   = 32'h55;
        #1 chk("arb_ready", 32'(bus.ld_ready), 32'd1);
        cycle();
        bus.ld_valid = 1'b0;
        cycle();
        cycle();
        bus.cpu_we = 1'b0;
        #1;
        chk("arb_cpu_first", bus.cpu_rdata, 32'h11);
        chk("arb_pending",   32'(bus.ld_idle), 32'd0);
        cycle();
        #1;
        chk("arb_loader_final", bus.cpu_rdata, 32'h55);
        chk("arb_idle",         32'(bus.ld_idle), 32'd1);
        cycle();

        // Result port vs same-cycle CPU write.
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 5'd7;
        bus.cpu_wdata = 32'hBEEF;
        bus.res_rd    = 1'b1;
        bus.res_addr  = 5'd7;
        cycle();
        bus.cpu_we = 1'b0;
        #1;
        chk("res_old_valid", 32'(bus.res_valid), 32'd1);
        chk("res_old_data",  bus.res_data, 32'h0);
        chk("res_cpu_vis",   bus.cpu_rdata, 32'hBEEF);
        cycle();
        bus.res_rd = 1'b0;
        #1;
        chk("res_new_valid", 32'(bus.res_valid), 32'd1);
        chk("res_new_data",  bus.res_data, 32'hBEEF);
        cycle();

        // Vector table of CPU writes/reads.
        for (int i = 0; i < 8; i++) begin
            bus.cpu_we    = vecs[i].we;
            bus.cpu_addr  = vecs[i].addr;
            bus.cpu_wdata = vecs[i].wdata;
            cycle();
            bus.cpu_we = 1'b0;
            #1 chk("vec", bus.cpu_rdata, vecs[i].exp_rd);
        end
        cycle();

`ifdef MEM_BYTE_WE_EN
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 5'd12;
        bus.cpu_wdata = 32'hFFFF_FFFF;
        bus.cpu_be    = 4'hF;
        cycle();
        bus.cpu_wdata = 32'h0000_0000;
        bus.cpu_be    = 4'b0101;
        cycle();
        bus.cpu_be    = 4'hF;
        expect_word("byte_we", 5'd12, 32'hFF00_FF00);
`endif

        // Reset with two words queued behind CPU writes.
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 5'd9;
        bus.cpu_wdata = 32'h99;
        push_word(5'd10, 32'hDEAD);
        push_word(5'd11, 32'hBEAD);
        bus.ld_valid = 1'b0;
        #1;
        chk("queued_full", 32'(bus.ld_ready), 32'd0);
        chk("queued_busy", 32'(bus.ld_idle),  32'd0);
        bus.cpu_we = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            expect_word("flush_10", 5'd10, 32'h0);
            expect_word("flush_11", 5'd11, 32'h0);
        end
        chk("flush_idle", 32'(bus.ld_idle), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(299) == 0);
            bus.cpu_we    = ($urandom_range(9) < 3);
            bus.cpu_addr  = AW'($urandom_range(DEPTH - 1));
            bus.cpu_wdata = $urandom;
`ifdef MEM_BYTE_WE_EN
            bus.cpu_be    = 4'($urandom_range(15));
`endif
            bus.ld_valid  = ($urandom_range(1) == 1);
            bus.ld_addr   = AW'($urandom_range(DEPTH - 1));
            bus.ld_data   = $urandom;
            bus.res_rd    = ($urandom_range(2) == 0);
            bus.res_addr  = AW'($urandom_range(DEPTH - 1));
            cycle();
        end
        rst = 1'b0;
        set_idle();
        for (int i = 0; i < 40; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
